// File: rtl/text_buffer_ctrl_pkg.sv
// Shared constants, state encoding and cell-address helper for the text buffer.
package text_buffer_ctrl_pkg;

    localparam int COLS  = 80;
    localparam int ROWS  = 30;
    localparam int CELLS = COLS * ROWS;

    localparam logic [6:0] ASCII_SP    = 7'h20;
    localparam logic [6:0] ASCII_CR    = 7'h0D;
    localparam logic [6:0] ASCII_BS    = 7'h08;
    localparam logic [6:0] ASCII_TILDE = 7'h7E;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        CLEAR = 2'd2
    } state_t;

    // row*80 + col without a multiplier
    function automatic logic [11:0] lin_addr(input logic [4:0] row, input logic [6:0] col);
        return ({7'd0, row} << 6) + ({7'd0, row} << 4) + {5'd0, col};
    endfunction

endpackage

// File: rtl/text_buffer_ctrl_ram.sv
// Simple dual-port character RAM: one write port, one registered read port.
module text_ram_dp #(
    parameter int AW = 12,
    parameter int DW = 7
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic          i_re,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_q
);

    logic [DW-1:0] r_mem [0:(1<<AW)-1];
    logic [DW-1:0] r_q;

    // Read-before-write: a same-address access returns the old contents.
    always_ff @(posedge i_clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
        if (i_re) r_q <= r_mem[i_raddr];
    end

    assign o_q = r_q;

endmodule

// File: rtl/text_buffer_ctrl.sv
// 80x30 character buffer: cursor writes, clear sweep, cursor blink and a
// two-tick pixel-to-font-ROM-address pipeline.
module text_buffer_ctrl
    import text_buffer_ctrl_pkg::*;
#(
    parameter int BLINK_FR = 32
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_tick,
    input  logic        i_video_on,
    input  logic [9:0]  i_pixel_x,
    input  logic [9:0]  i_pixel_y,
    input  logic [6:0]  i_wr_char,
    input  logic        i_wr_stb,
    input  logic        i_clr_stb,
    output logic        o_busy,
    output logic [10:0] o_rom_addr,
    output logic        o_cursor_on,
    output logic [6:0]  o_cur_col,
    output logic [4:0]  o_cur_row
);

    localparam int BW = (BLINK_FR > 1) ? $clog2(BLINK_FR) : 1;
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FR - 1);
    localparam logic [6:0]  LAST_COL  = 7'(COLS - 1);
    localparam logic [4:0]  LAST_ROW  = 5'(ROWS - 1);
    localparam logic [11:0] LAST_CELL = 12'(CELLS - 1);

    state_t        r_state, w_state_nxt;
    logic [11:0]   r_clr_addr;
    logic [6:0]    r_col, w_col_nxt;
    logic [4:0]    r_row, w_row_nxt, w_row_inc;
    logic [6:0]    r_wr_char;
    logic          w_we;
    logic [11:0]   w_waddr;
    logic [6:0]    w_wdata;
    logic [BW-1:0] r_blink_cnt;
    logic          r_blink_phase;
    logic          w_frame;

    logic [11:0]   r_lin_d1;
    logic [3:0]    r_yline_d1, r_yline_d2;
    logic [6:0]    r_col_d1, r_col_d2;
    logic [4:0]    r_row_d1, r_row_d2;
    logic          r_vis_d1, r_vis_d2;
    logic          r_primed;
    logic [6:0]    w_ram_q, w_char_d2;
    logic          w_in_range;

    assign w_row_inc = (r_row == LAST_ROW) ? 5'd0 : r_row + 5'd1;

    always_comb begin
        w_state_nxt = r_state;
        w_col_nxt   = r_col;
        w_row_nxt   = r_row;
        w_we        = 1'b0;
        w_waddr     = lin_addr(r_row, r_col);
        w_wdata     = r_wr_char;
        case (r_state)
            IDLE: begin
                if (i_clr_stb)     w_state_nxt = CLEAR;
                else if (i_wr_stb) w_state_nxt = WRITE;
            end
            WRITE: begin
                w_state_nxt = IDLE;
                if (r_wr_char >= ASCII_SP && r_wr_char <= ASCII_TILDE) begin
                    w_we = 1'b1;
                    if (r_col == LAST_COL) begin
                        w_col_nxt = 7'd0;
                        w_row_nxt = w_row_inc;
                    end else begin
                        w_col_nxt = r_col + 7'd1;
                    end
                end else if (r_wr_char == ASCII_CR) begin
                    w_col_nxt = 7'd0;
                    w_row_nxt = w_row_inc;
                end else if (r_wr_char == ASCII_BS && r_col != 7'd0) begin
                    w_col_nxt = r_col - 7'd1;
                    w_we      = 1'b1;
                    w_waddr   = lin_addr(r_row, r_col - 7'd1);
                    w_wdata   = ASCII_SP;
                end
            end
            CLEAR: begin
                w_we    = 1'b1;
                w_waddr = r_clr_addr;
                w_wdata = ASCII_SP;
                if (r_clr_addr == LAST_CELL) begin
                    w_state_nxt = IDLE;
                    w_col_nxt   = 7'd0;
                    w_row_nxt   = 5'd0;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state    <= CLEAR;
            r_clr_addr <= 12'd0;
            r_col      <= 7'd0;
            r_row      <= 5'd0;
            r_wr_char  <= 7'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_col      <= w_col_nxt;
            r_row      <= w_row_nxt;
            r_clr_addr <= (r_state == CLEAR && r_clr_addr != LAST_CELL) ? r_clr_addr + 12'd1 : 12'd0;
            if (r_state == IDLE && i_wr_stb) r_wr_char <= i_wr_char;
        end
    end

    assign w_frame = i_tick && (i_pixel_x == 10'd0) && (i_pixel_y == 10'd0);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b0;
        end else if (r_state == CLEAR) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b0;
        end else if (w_frame) begin
            if (r_blink_cnt == BLINK_LAST) begin
                r_blink_cnt   <= '0;
                r_blink_phase <= ~r_blink_phase;
            end else begin
                r_blink_cnt <= r_blink_cnt + 1'b1;
            end
        end
    end

    assign w_in_range = (i_pixel_x[9:3] < 7'(COLS)) && (i_pixel_y[9:4] < 6'(ROWS));

    // Visibility and range are folded into one flag at S1; S2 forces blanks from it.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_lin_d1   <= 12'd0;
            r_yline_d1 <= 4'd0;
            r_col_d1   <= 7'd0;
            r_row_d1   <= 5'd0;
            r_vis_d1   <= 1'b0;
            r_yline_d2 <= 4'd0;
            r_col_d2   <= 7'd0;
            r_row_d2   <= 5'd0;
            r_vis_d2   <= 1'b0;
            r_primed   <= 1'b0;
        end else if (i_tick) begin
            r_lin_d1   <= lin_addr(i_pixel_y[8:4], i_pixel_x[9:3]);
            r_yline_d1 <= i_pixel_y[3:0];
            r_col_d1   <= i_pixel_x[9:3];
            r_row_d1   <= i_pixel_y[8:4];
            r_vis_d1   <= i_video_on & w_in_range;
            r_yline_d2 <= r_yline_d1;
            r_col_d2   <= r_col_d1;
            r_row_d2   <= r_row_d1;
            r_vis_d2   <= r_vis_d1;
            r_primed   <= 1'b1;
        end
    end

    text_ram_dp #(.AW(12), .DW(7)) u_ram (
        .i_clk   (i_clk),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (w_wdata),
        .i_re    (i_tick),
        .i_raddr (r_lin_d1),
        .o_q     (w_ram_q)
    );

    // The RAM output register has no reset, so hold the address at zero until the pipe has advanced.
    assign w_char_d2   = r_vis_d2 ? w_ram_q : ASCII_SP;
    assign o_rom_addr  = r_primed ? {w_char_d2, r_yline_d2} : 11'd0;
    assign o_cursor_on = r_blink_phase & r_vis_d2 & (r_col_d2 == r_col) & (r_row_d2 == r_row);
    assign o_busy      = (r_state == CLEAR);
    assign o_cur_col   = r_col;
    assign o_cur_row   = r_row;

endmodule

// File: tb/tb_text_buffer_ctrl.sv
// Randomized bench for text_buffer_ctrl against a cell-array reference model.
module tb_text_buffer_ctrl;

    localparam int NCOLS = 80;
    localparam int NROWS = 30;
    localparam int BLINK = 32;

    logic        clk = 1'b0;
    logic        reset, tick, video_on, wr_stb, clr_stb;
    logic [9:0]  px, py;
    logic [6:0]  wr_char;
    logic        busy, cursor_on;
    logic [10:0] rom_addr;
    logic [6:0]  cur_col;
    logic [4:0]  cur_row;

    int n_checks = 0;
    int n_fail   = 0;

    logic [6:0] m_mem [0:NCOLS*NROWS-1];
    int m_col, m_row, m_frames;

    bit p_valid, have_last;
    int p_x, p_y;
    bit p_vid;
    logic [10:0] last_exp;

    text_buffer_ctrl #(.BLINK_FR(BLINK)) dut (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_tick      (tick),
        .i_video_on  (video_on),
        .i_pixel_x   (px),
        .i_pixel_y   (py),
        .i_wr_char   (wr_char),
        .i_wr_stb    (wr_stb),
        .i_clr_stb   (clr_stb),
        .o_busy      (busy),
        .o_rom_addr  (rom_addr),
        .o_cursor_on (cursor_on),
        .o_cur_col   (cur_col),
        .o_cur_row   (cur_row)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit in_cell(input int x, input int y, input bit vid);
        return vid && (x / 8 < NCOLS) && (y / 16 < NROWS);
    endfunction

    function automatic logic [10:0] exp_rom(input int x, input int y, input bit vid);
        logic [6:0] ch;
        ch = in_cell(x, y, vid) ? m_mem[(y / 16) * NCOLS + x / 8] : 7'h20;
        return {ch, 4'(y % 16)};
    endfunction

    function automatic bit exp_cur(input int x, input int y, input bit vid);
        bit phase;
        phase = ((m_frames / BLINK) % 2) == 1;
        return in_cell(x, y, vid) && (x / 8 == m_col) && (y / 16 == m_row) && phase;
    endfunction

    task automatic m_next_row();
        m_row = (m_row == NROWS - 1) ? 0 : m_row + 1;
    endtask

    task automatic m_write(input logic [6:0] c);
        if (c >= 7'h20 && c <= 7'h7E) begin
            m_mem[m_row * NCOLS + m_col] = c;
            if (m_col == NCOLS - 1) begin
                m_col = 0;
                m_next_row();
            end else begin
                m_col++;
            end
        end else if (c == 7'h0D) begin
            m_col = 0;
            m_next_row();
        end else if (c == 7'h08 && m_col > 0) begin
            m_col--;
            m_mem[m_row * NCOLS + m_col] = 7'h20;
        end
    endtask

    task automatic m_clear();
        for (int i = 0; i < NCOLS * NROWS; i++) m_mem[i] = 7'h20;
        m_col = 0;
        m_row = 0;
        m_frames = 0;
    endtask

    task automatic scan_begin();
        p_valid = 0;
        have_last = 0;
    endtask

    task automatic step(input int x, input int y, input bit vid);
        @(negedge clk);
        px = 10'(x);
        py = 10'(y);
        video_on = vid;
        tick = 1'b1;
        @(posedge clk);
        if (x == 0 && y == 0) m_frames++;
        #1;
        tick = 1'b0;
        if (p_valid) begin
            last_exp = exp_rom(p_x, p_y, p_vid);
            chk("rom_addr", 32'(rom_addr), 32'(last_exp));
            chk("cursor_on", 32'(cursor_on), 32'(exp_cur(p_x, p_y, p_vid)));
            have_last = 1;
        end
        p_x = x;
        p_y = y;
        p_vid = vid;
        p_valid = 1;
    endtask

    task automatic stall();
        @(negedge clk);
        tick = 1'b0;
        px = 10'($urandom_range(1, 1023));
        py = 10'($urandom_range(1, 1023));
        @(posedge clk);
        #1;
        if (have_last) chk("stall_hold", 32'(rom_addr), 32'(last_exp));
    endtask

    task automatic scan_all();
        scan_begin();
        for (int r = 0; r < NROWS; r++)
            for (int c = 0; c < NCOLS; c++) begin
                step(c * 8 + int'($urandom_range(0, 7)), r * 16 + int'($urandom_range(0, 15)), 1'b1);
                if ($urandom_range(0, 15) == 0) stall();
            end
        step(int'($urandom_range(640, 1023)), int'($urandom_range(0, 479)), 1'b1);
        step(int'($urandom_range(8, 639)), int'($urandom_range(480, 1023)), 1'b1);
        step(int'($urandom_range(8, 639)), int'($urandom_range(16, 479)), 1'b0);
        step(100, 100, 1'b1);
    endtask

    task automatic wr(input logic [6:0] c);
        @(negedge clk);
        wr_char = c;
        wr_stb = 1'b1;
        @(negedge clk);
        wr_stb = 1'b0;
        @(negedge clk);
        m_write(c);
        chk("cur_col", 32'(cur_col), 32'(m_col));
        chk("cur_row", 32'(cur_row), 32'(m_row));
    endtask

    // Entered at a negedge with the clear sweep already running for n_start edges.
    task automatic wait_clear(input int n_start);
        int n;
        n = n_start;
        while (busy && n < 3000) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        chk("busy_len", 32'(n), 32'(NCOLS * NROWS));
        m_clear();
        chk("clr_col", 32'(cur_col), 32'd0);
        chk("clr_row", 32'(cur_row), 32'd0);
    endtask

    task automatic clr();
        @(negedge clk);
        clr_stb = 1'b1;
        @(negedge clk);
        clr_stb = 1'b0;
        chk("busy_start", 32'(busy), 32'd1);
        wait_clear(0);
    endtask

    function automatic logic [6:0] rand_char();
        int k;
        k = $urandom_range(0, 99);
        if (k < 50) return 7'($urandom_range(32'h20, 32'h7E));
        if (k < 65) return 7'h0D;
        if (k < 80) return 7'h08;
        if (k < 90) return 7'h7F;
        return 7'($urandom_range(0, 31));
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        tick = 1'b0;
        video_on = 1'b0;
        px = 10'd100;
        py = 10'd100;
        wr_char = 7'd0;
        wr_stb = 1'b0;
        clr_stb = 1'b0;
        m_clear();
        #17;
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_rom", 32'(rom_addr), 32'd0);
        chk("rst_cursor_on", 32'(cursor_on), 32'd0);
        chk("rst_col", 32'(cur_col), 32'd0);
        chk("rst_row", 32'(cur_row), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        wait_clear(0);
        scan_all();

        wr(7'h41);
        scan_begin();
        for (int y = 0; y < 16; y++)
            for (int x = 0; x < 8; x++) step(x, y, 1'b1);
        step(200, 200, 1'b1);

        for (int i = 0; i < 29; i++) wr(7'h0D);
        for (int i = 0; i < 79; i++) wr(7'h78);
        wr(7'h42);
        wr(7'h0D);
        wr(7'h0D);
        wr(7'h08);
        wr(7'h61);
        wr(7'h62);
        wr(7'h63);
        wr(7'h08);
        wr(7'h0D);
        for (int i = 0; i < 5; i++) wr(7'h30 + 7'(i));
        wr(7'h0D);
        scan_all();

        for (int i = 0; i < 300; i++) wr(rand_char());
        scan_all();

        @(negedge clk);
        clr_stb = 1'b1;
        wr_stb = 1'b1;
        wr_char = 7'h51;
        @(negedge clk);
        clr_stb = 1'b0;
        wr_stb = 1'b0;
        chk("clr_wins_busy", 32'(busy), 32'd1);
        repeat (100) @(negedge clk);
        wr_char = 7'h5A;
        wr_stb = 1'b1;
        @(negedge clk);
        wr_stb = 1'b0;
        wait_clear(101);
        scan_all();

        for (int i = 0; i < 40; i++) wr(rand_char());
        clr();
        wr(7'h4D);
        @(negedge clk);
        clr_stb = 1'b1;
        @(negedge clk);
        clr_stb = 1'b0;
        repeat (500) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("mid_rst_busy", 32'(busy), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        wait_clear(0);

        for (int i = 0; i < 5; i++) wr(7'h0D);
        for (int i = 0; i < 10; i++) wr(7'h78);
        scan_begin();
        for (int f = 0; f < 100; f++) begin
            step(0, 0, 1'b1);
            step(m_col * 8 + int'($urandom_range(0, 7)), m_row * 16 + int'($urandom_range(0, 15)), 1'b1);
            step(m_col * 8 + 8, m_row * 16, 1'b1);
            step(int'($urandom_range(640, 1023)), m_row * 16 + 3, 1'b1);
            step(m_col * 8 + 2, m_row * 16 + 5, 1'b0);
            step(m_col * 8 + 4, m_row * 16 + 7, 1'b1);
        end
        step(300, 300, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
